// File: rtl/core_seq_if.sv
// Handshake/bus bundle between core_seq, instruction memory and the ALU/register stage.
interface core_seq_if #(
  parameter int DATASIZE = 8,
  parameter int IENBSIZE = 6
);
  logic                run;
  logic                mem_rdy;
  logic [DATASIZE-1:0] bus_d;
  logic                mem_rd;
  logic [IENBSIZE-1:0] ienb;
  logic                halt;
  logic                ill;

  modport master (
    input  run, mem_rdy, bus_d,
    output mem_rd, ienb, halt, ill
  );

  modport slave (
    output run, mem_rdy, bus_d,
    input  mem_rd, ienb, halt, ill
  );
endinterface

// File: rtl/core_seq.sv
// Instruction sequencer: fetches an opcode (plus an immediate for MVI) and steps the
// ALU/register stage through read/write enables. Outputs are decoded from state only.
module core_seq #(
  parameter int DATASIZE = 8,
  parameter int IENBSIZE = 6,
  parameter int IENB_COD = 0,
  parameter int IENB_DAT = 1,
  parameter int IENB_PC_ = 2,
  parameter int IENB_PD_ = 3,
  parameter int IENB_RRD = 4,
  parameter int IENB_RWR = 5
) (
  input logic         clk,
  input logic         rst,
  core_seq_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE, FETCH, LATCH_C, FETCH_D, LATCH_D, EXEC_RD, EXEC_WR, HALT
  } state_e;

  state_e              state_q, state_d;
  logic [DATASIZE-1:0] opcode_q, opcode_d;
  logic                ill_q, ill_d;

  logic                mem_rd_c;
  logic [IENBSIZE-1:0] ienb_c;
  logic                halt_c;

  logic [1:0] grp;
  logic [2:0] dst, src;
  logic       is_halt, is_nop, is_mvi, is_mov, is_alu;

  assign grp     = opcode_q[7:6];
  assign dst     = opcode_q[5:3];
  assign src     = opcode_q[2:0];
  assign is_halt = (opcode_q[7:0] == 8'h76);
  assign is_nop  = (opcode_q[7:0] == 8'h00);
  assign is_mvi  = (grp == 2'b00) && (src == 3'b110) && (dst != 3'b110);
  assign is_mov  = (grp == 2'b01) && (src != 3'b110) && (dst != 3'b110);
  assign is_alu  = (grp == 2'b10) && (src != 3'b110);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      opcode_q <= '0;
      ill_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      ill_q    <= ill_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    ill_d    = 1'b0;
    mem_rd_c = 1'b0;
    ienb_c   = '0;
    halt_c   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.run) state_d = FETCH;
      end
      FETCH: begin
        mem_rd_c = 1'b1;
        if (bus.mem_rdy) begin
          opcode_d = bus.bus_d;
          state_d  = LATCH_C;
        end
      end
      LATCH_C: begin
        mem_rd_c         = 1'b1;
        ienb_c[IENB_COD] = 1'b1;
        ienb_c[IENB_PC_] = 1'b1;
        // 8'h76 overlaps the MOV field pattern, so it must win first.
        if (is_halt)               state_d = HALT;
        else if (is_nop)           state_d = IDLE;
        else if (is_mvi)           state_d = FETCH_D;
        else if (is_mov || is_alu) state_d = EXEC_RD;
        else begin
          state_d = IDLE;
          ill_d   = 1'b1;
        end
      end
      FETCH_D: begin
        mem_rd_c = 1'b1;
        if (bus.mem_rdy) state_d = LATCH_D;
      end
      LATCH_D: begin
        mem_rd_c         = 1'b1;
        ienb_c[IENB_DAT] = 1'b1;
        ienb_c[IENB_PC_] = 1'b1;
        state_d          = EXEC_RD;
      end
      EXEC_RD: begin
        ienb_c[IENB_RRD] = 1'b1;
        state_d          = EXEC_WR;
      end
      EXEC_WR: begin
        ienb_c[IENB_RRD] = 1'b1;
        ienb_c[IENB_RWR] = 1'b1;
        state_d          = IDLE;
      end
      HALT: begin
        halt_c = 1'b1;
      end
    endcase
  end

  assign bus.mem_rd = mem_rd_c;
  assign bus.ienb   = ienb_c;
  assign bus.halt   = halt_c;
  assign bus.ill    = ill_q;

endmodule

// File: tb/tb_core_seq.sv
// Randomized bench for core_seq: each instruction is expanded into its expected
// per-cycle output trace and compared cycle by cycle, plus literal latency checks.
module tb_core_seq;
  localparam int DW = 8;
  localparam int IW = 6;

  localparam logic [5:0] E_COD = 6'b000001;
  localparam logic [5:0] E_DAT = 6'b000010;
  localparam logic [5:0] E_PC  = 6'b000100;
  localparam logic [5:0] E_RRD = 6'b010000;
  localparam logic [5:0] E_RWR = 6'b100000;

  localparam int C_NOP  = 0;
  localparam int C_HALT = 1;
  localparam int C_MVI  = 2;
  localparam int C_EX   = 3;
  localparam int C_ILL  = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  core_seq_if #(.DATASIZE(DW), .IENBSIZE(IW)) bus_if ();

  core_seq #(
    .DATASIZE(DW), .IENBSIZE(IW),
    .IENB_COD(0), .IENB_DAT(1), .IENB_PC_(2), .IENB_PD_(3), .IENB_RRD(4), .IENB_RWR(5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.master)
  );

  int         errors = 0;
  int         checks = 0;
  logic       chk_en = 1'b0;
  logic [8:0] exp_vec = '0;
  logic       ill_pend = 1'b0;
  logic [7:0] dat_seen = '0;
  logic [8:0] act;

  // Observed output vector: {mem_rd, halt, ill, ienb}
  assign act = {bus_if.mem_rd, bus_if.halt, bus_if.ill, bus_if.ienb};

  function automatic logic [8:0] ov(input logic rd, input logic hl, input logic il,
                                    input logic [5:0] en);
    return {rd, hl, il, en};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [7:0] rb8();
    return 8'($urandom);
  endfunction

  // Instruction class straight from the opcode table.
  function automatic int classify(input logic [7:0] op);
    logic [1:0] g;
    logic [2:0] d, s;
    g = op[7:6];
    d = op[5:3];
    s = op[2:0];
    if (op == 8'h76) return C_HALT;
    if (op == 8'h00) return C_NOP;
    if (g == 2'd0 && s == 3'd6 && d != 3'd6) return C_MVI;
    if (g == 2'd1 && d != 3'd6 && s != 3'd6) return C_EX;
    if (g == 2'd2 && s != 3'd6) return C_EX;
    return C_ILL;
  endfunction

  task automatic check(input string nm, input logic [8:0] a, input logic [8:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got {rd,halt,ill,ienb}=%b expected %b at %0t", nm, a, e, $time);
    end
  endtask

  task automatic check_int(input string nm, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, a, e);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      checks++;
      if (bus_if.ienb[3] !== 1'b0 || (bus_if.ienb[0] && bus_if.ienb[1]) ||
          (bus_if.ienb[5] && !bus_if.ienb[4])) begin
        errors++;
        $display("FAIL enable_invariant: got ienb=%b required PD_=0, not COD&DAT, RWR only with RRD at %0t",
                 bus_if.ienb, $time);
      end
      if (chk_en) check("cycle", act, exp_vec);
      if (bus_if.ienb[1]) dat_seen = bus_if.bus_d;
    end
  end

  // One clock cycle: inputs to be sampled at the next edge, outputs expected now.
  task automatic cyc(input logic r, input logic rdy, input logic [7:0] bd, input logic [8:0] e);
    @(posedge clk);
    #1;
    bus_if.run     = r;
    bus_if.mem_rdy = rdy;
    bus_if.bus_d   = bd;
    exp_vec        = e;
    chk_en         = 1'b1;
  endtask

  task automatic idle();
    cyc(1'b0, rb(), rb8(), ov(1'b0, 1'b0, ill_pend, '0));
    ill_pend = 1'b0;
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    #2;
    rst        = 1'b0;
    chk_en     = 1'b0;
    bus_if.run = 1'b0;
    ill_pend   = 1'b0;
    #1 check("async_reset", act, '0);
    @(negedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic do_op(input logic [7:0] op, input logic [7:0] dat, input int w1, input int w2,
                       input bit abort_rd, output int lat);
    int c;
    c   = classify(op);
    lat = 0;
    cyc(1'b1, rb(), rb8(), ov(1'b0, 1'b0, ill_pend, '0));
    ill_pend = 1'b0;
    for (int i = 0; i < w1; i++) begin
      cyc(rb(), 1'b0, rb8(), ov(1'b1, 1'b0, 1'b0, '0));
      lat++;
    end
    cyc(rb(), 1'b1, op, ov(1'b1, 1'b0, 1'b0, '0));
    lat++;
    cyc(rb(), rb(), op, ov(1'b1, 1'b0, 1'b0, E_COD | E_PC));
    lat++;
    if (c == C_HALT) begin
      for (int i = 0; i < 20; i++) cyc(1'b1, rb(), rb8(), ov(1'b0, 1'b1, 1'b0, '0));
      reset_pulse();
      return;
    end
    if (c == C_ILL) ill_pend = 1'b1;
    if (c == C_MVI) begin
      for (int i = 0; i < w2; i++) begin
        cyc(rb(), 1'b0, rb8(), ov(1'b1, 1'b0, 1'b0, '0));
        lat++;
      end
      cyc(rb(), 1'b1, dat, ov(1'b1, 1'b0, 1'b0, '0));
      lat++;
      cyc(rb(), rb(), dat, ov(1'b1, 1'b0, 1'b0, E_DAT | E_PC));
      lat++;
    end
    if (c == C_MVI || c == C_EX) begin
      cyc(rb(), rb(), rb8(), ov(1'b0, 1'b0, 1'b0, E_RRD));
      lat++;
      if (abort_rd) begin
        reset_pulse();
        return;
      end
      cyc(rb(), rb(), rb8(), ov(1'b0, 1'b0, 1'b0, E_RRD | E_RWR));
      lat++;
    end
  endtask

  initial begin
    int         lat;
    logic [7:0] op;
    bus_if.run     = 1'b0;
    bus_if.mem_rdy = 1'b0;
    bus_if.bus_d   = '0;
    #3 check("reset_state", act, '0);
    #10;
    @(negedge clk);
    #1 rst = 1'b1;
    repeat (3) idle();

    do_op(8'h3E, 8'hAA, 0, 0, 1'b0, lat);
    check_int("mvi_latency", lat, 6);
    check_int("mvi_a_data", int'(dat_seen), 8'hAA);

    do_op(8'h47, 8'h00, 3, 0, 1'b0, lat);
    check_int("mov_wait_latency", lat, 7);

    do_op(8'hAF, 8'h00, 0, 0, 1'b0, lat);
    check_int("xra_latency", lat, 4);
    do_op(8'h00, 8'h00, 0, 0, 1'b0, lat);
    check_int("nop_latency", lat, 2);

    do_op(8'h7E, 8'h00, 0, 0, 1'b0, lat);
    check_int("ill_latency", lat, 2);
    idle();

    do_op(8'hBF, 8'h00, 1, 0, 1'b0, lat);
    check_int("cmp_latency", lat, 5);

    do_op(8'h76, 8'h00, 0, 0, 1'b0, lat);

    do_op(8'h47, 8'h00, 0, 0, 1'b1, lat);
    do_op(8'h47, 8'h00, 0, 0, 1'b0, lat);
    check_int("post_reset_mov_latency", lat, 4);

    do_op(8'h06, 8'h5C, 2, 3, 1'b0, lat);
    check_int("mvi_wait_latency", lat, 11);
    check_int("mvi_b_data", int'(dat_seen), 8'h5C);

    for (int n = 0; n < 250; n++) begin
      case ($urandom_range(0, 3))
        0:       op = {2'b00, 3'($urandom), 3'b110};
        1:       op = {2'b01, 6'($urandom)};
        2:       op = {2'b10, 6'($urandom)};
        default: op = rb8();
      endcase
      do_op(op, rb8(), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            ($urandom_range(0, 19) == 0), lat);
      repeat ($urandom_range(0, 2)) idle();
    end
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/core_seq.md
CORE_SEQ -- requirements
Module: core_seq

Interface
REQ-001 SHALL have parameter DATASIZE, default 8, meaning data/opcode bus width.
REQ-002 SHALL have parameter IENBSIZE, default 6, meaning width of the enable vector.
REQ-003 SHALL have parameters IENB_COD=0, IENB_DAT=1, IENB_PC_=2, IENB_PD_=3, IENB_RRD=4, IENB_RWR=5, meaning the bit positions in ienb.
REQ-004 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port run  input  1  enables instruction sequencing; sampled only in IDLE.
REQ-007 SHALL have port mem_rdy  input  1  memory read-data-valid strobe.
REQ-008 SHALL have port bus_d  input  DATASIZE  memory read data; the same bus feeds the ALU/register stage.
REQ-009 SHALL have port mem_rd  output  1  memory read request.
REQ-010 SHALL have port ienb  output  IENBSIZE  enable vector to the ALU/register stage.
REQ-011 SHALL have port halt  output  1  high while in HALT.
REQ-012 SHALL have port ill  output  1  one-cycle pulse on an unsupported opcode.

Function
REQ-013 SHALL implement Moore FSM states IDLE, FETCH, LATCH_C, FETCH_D, LATCH_D, EXEC_RD, EXEC_WR, HALT; all outputs SHALL be registered or decoded from state only.
REQ-014 IDLE: all outputs 0; goes to FETCH when run=1, otherwise stays.
REQ-015 FETCH: mem_rd=1; stays while mem_rdy=0 (no timeout); when mem_rdy=1, SHALL capture bus_d into internal opcode register and go to LATCH_C.
REQ-016 LATCH_C: mem_rd=1, ienb[IENB_COD]=1, ienb[IENB_PC_]=1 for exactly one cycle; memory SHALL hold bus_d while mem_rd=1.
REQ-017 Decode from captured opcode, leaving LATCH_C: 8'h76 -> HALT; 8'h00 -> IDLE; 00ddd110 with ddd!=110 (MVI r) -> FETCH_D; 01dddsss, neither field 110 (MOV) -> EXEC_RD; 10ooosss with sss!=110 (ALU) -> EXEC_RD; anything else -> IDLE with ill=1 for one cycle.
REQ-018 FETCH_D: mem_rd=1; waits on mem_rdy exactly as FETCH; then LATCH_D.
REQ-019 LATCH_D: mem_rd=1, ienb[IENB_DAT]=1, ienb[IENB_PC_]=1 for one cycle; then EXEC_RD.
REQ-020 EXEC_RD: ienb[IENB_RRD]=1 only; then EXEC_WR.
REQ-021 EXEC_WR: ienb[IENB_RRD]=1 and ienb[IENB_RWR]=1 for one cycle; then IDLE. CMP (ooo=111) SHALL use the same sequence; suppressing the register write is the downstream stage's job.
REQ-022 ienb[IENB_PD_] SHALL be 0 at all times.
REQ-023 Latency with mem_rdy=1 in the first FETCH cycle: NOP 2 cycles, MOV/ALU 4, MVI 6, counted FETCH entry to IDLE re-entry.
REQ-024 Each wait state adds exactly one cycle; no enable SHALL assert during a wait.
REQ-025 HALT: halt=1, all other outputs 0; left only by reset; run ignored.
REQ-026 run SHALL NOT abort an instruction in progress; deasserting run mid-instruction stops sequencing at the next IDLE.
REQ-027 At most one of IENB_COD, IENB_DAT SHALL be high in any cycle; ienb[IENB_RWR] SHALL never be high without ienb[IENB_RRD].

Reset
REQ-028 rst=0 SHALL force, without waiting for clk: state IDLE, mem_rd=0, ienb=0, halt=0, ill=0, opcode register 8'h00.
REQ-029 Reset asserted in any state, including mid-wait or mid-EXEC, SHALL abandon the instruction with no further enables.
REQ-030 After rst rises, the first FETCH SHALL occur no earlier than the first rising clk edge with run=1.

Verification
REQ-031 MVI A: run=1, bus_d=8'h3E then 8'hAA, mem_rdy=1 -> COD+PC_ pulse, DAT+PC_ pulse, RRD, RRD+RWR; 6 cycles; downstream A=8'hAA.
REQ-032 MOV B,A (8'h47) with mem_rdy held 0 for 3 cycles -> mem_rd high 4 FETCH cycles; then COD, RRD, RRD+RWR; 7 cycles total; no enable during the wait.
REQ-033 XRA A (8'hAF) then NOP (8'h00) back-to-back -> 4 cycles then 2 cycles; NOP produces only COD+PC_.
REQ-034 Opcode 8'h7E (MOV A,M) -> ill pulse 1 cycle, no RRD/RWR, return to IDLE; 8'h76 -> halt=1 held 20 cycles with run=1 and no mem_rd.
REQ-035 rst=0 asserted asynchronously during EXEC_RD of 8'h47 -> ienb=0 and mem_rd=0 before the next clk edge; after release with run=1, a clean FETCH.
REQ-036 A bench assertion SHALL check REQ-022 and REQ-027 every cycle across all scenarios.
